snn_axon_scheduler: RTL and testbench

Upstream sequencer for the 16-neuron NVM neuron block. It holds one binary input picture as an axon bitmap and walks it one axon per cycle. For every active axon it fetches that axon's 16-bit connection row from the synapse matrix through a req/ack handshake, then drives the `stimuli`, `connection` and `enable` pulses the neuron block accumulates. After the last axon it applies a threshold bias pulse, captures the neuron spike vector, and pulses `picture_done` to clear the neuron potentials.

---
 rtl/snn_axon_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_snn_axon_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_axon_scheduler.sv
// snn_axon_scheduler
// Walks a stored axon bitmap one axon per cycle. Each active axon has its
// connection row fetched from the synapse matrix, and that row is then
// presented to the neuron block as an accumulate pulse. After the last axon
// the block applies a threshold bias pulse, samples the spike vector and
// clears the neuron potentials with picture_done.
//
// Synapse handshake (req/ack):
//   syn_req rises together with syn_addr and both stay stable until syn_ack
//   is sampled high on a rising clk edge. syn_data is taken on that same
//   edge, and syn_req drops on it. Only one request is ever outstanding.
//   syn_ack is ignored whenever no request is pending.
module snn_axon_scheduler #(
  parameter int NUM_AXONS  = 256,
  parameter int ADDR_W     = 8,
  parameter int NUM_NEURON = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pixel_we,
  input  logic [ADDR_W-6:0]     pixel_addr,
  input  logic [31:0]           pixel_wdata,
  input  logic signed [15:0]    stim_weight,
  input  logic signed [15:0]    bias,
  output logic                  syn_req,
  output logic [ADDR_W-1:0]     syn_addr,
  input  logic                  syn_ack,
  input  logic [NUM_NEURON-1:0] syn_data,
  output logic signed [15:0]    stimuli,
  output logic [NUM_NEURON-1:0] connection,
  output logic                  enable,
  output logic                  picture_done,
  input  logic [NUM_NEURON-1:0] spike_i,
  output logic [NUM_NEURON-1:0] spike_out,
  output logic                  spike_valid,
  output logic                  busy,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_BIAS   = 3'd4,
    ST_SAMPLE = 3'd5
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_AXONS - 1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [NUM_AXONS-1:0]    bitmap_q;

  logic                    syn_req_q, syn_req_d;
  logic [ADDR_W-1:0]       syn_addr_q, syn_addr_d;
  logic signed [15:0]      stimuli_q, stimuli_d;
  logic [NUM_NEURON-1:0]   connection_q, connection_d;
  logic                    enable_q, enable_d;
  logic                    picture_done_q, picture_done_d;
  logic [NUM_NEURON-1:0]   spike_out_q, spike_out_d;
  logic                    spike_valid_q, spike_valid_d;
  logic                    busy_q, busy_d;

  logic                    cur_bit;
  logic                    is_last;

  assign cur_bit = bitmap_q[idx_q];
  assign is_last = (idx_q == LAST_IDX);

  // Bitmap storage: word writes land only while the FSM is idle, so a
  // picture in flight never sees its pixels change underneath it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_q <= '0;
    end else if (pixel_we && (state_q == ST_IDLE)) begin
      bitmap_q[{pixel_addr, 5'd0} +: 32] <= pixel_wdata;
    end
  end

  // State register: FSM state, axon index and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      syn_req_q      <= 1'b0;
      syn_addr_q     <= '0;
      stimuli_q      <= '0;
      connection_q   <= '0;
      enable_q       <= 1'b0;
      picture_done_q <= 1'b0;
      spike_out_q    <= '0;
      spike_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      syn_req_q      <= syn_req_d;
      syn_addr_q     <= syn_addr_d;
      stimuli_q      <= stimuli_d;
      connection_q   <= connection_d;
      enable_q       <= enable_d;
      picture_done_q <= picture_done_d;
      spike_out_q    <= spike_out_d;
      spike_valid_q  <= spike_valid_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state logic: axon walk and the drain/bias/sample tail.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cur_bit) begin
          state_d = ST_WAIT;
        end else if (is_last) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (syn_ack) begin
          if (is_last) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DRAIN:  state_d = ST_BIAS;
      ST_BIAS:   state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Pulses default to
  // 0 and the data buses hold unless a pulse is being launched.
  always_comb begin
    syn_req_d      = syn_req_q;
    syn_addr_d     = syn_addr_q;
    stimuli_d      = stimuli_q;
    connection_d   = connection_q;
    enable_d       = 1'b0;
    picture_done_d = 1'b0;
    spike_out_d    = spike_out_q;
    spike_valid_d  = 1'b0;
    busy_d         = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (cur_bit) begin
          syn_req_d  = 1'b1;
          syn_addr_d = idx_q;
        end
      end
      ST_WAIT: begin
        if (syn_ack) begin
          syn_req_d    = 1'b0;
          connection_d = syn_data;
          stimuli_d    = stim_weight;
          enable_d     = 1'b1;
        end
      end
      ST_DRAIN: begin
        // The bias pulse reaches every neuron.
        connection_d = '1;
        stimuli_d    = bias;
        enable_d     = 1'b1;
      end
      ST_BIAS: begin
        picture_done_d = 1'b1;
      end
      ST_SAMPLE: begin
        // spike_i still holds the pre-clear result on this edge.
        spike_out_d   = spike_i;
        spike_valid_d = 1'b1;
        busy_d        = 1'b0;
      end
      default: begin
        syn_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign syn_req      = syn_req_q;
  assign syn_addr     = syn_addr_q;
  assign stimuli      = stimuli_q;
  assign connection   = connection_q;
  assign enable       = enable_q;
  assign picture_done = picture_done_q;
  assign spike_out    = spike_out_q;
  assign spike_valid  = spike_valid_q;
  assign busy         = busy_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_snn_axon_scheduler.sv
// tb_snn_axon_scheduler
// Drives pictures into the scheduler, emulates the synapse matrix and the
// 16-neuron accumulate block, and compares every pulse, request and spike
// result with a reference computed directly from the bitmap and rows.
module tb_snn_axon_scheduler;

  localparam int NA = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic               start = 1'b0;
  logic               pixel_we = 1'b0;
  logic [2:0]         pixel_addr = '0;
  logic [31:0]        pixel_wdata = '0;
  logic signed [15:0] stim_weight = '0;
  logic signed [15:0] bias = '0;
  logic               syn_req;
  logic [7:0]         syn_addr;
  logic               syn_ack = 1'b0;
  logic [15:0]        syn_data = '0;
  logic signed [15:0] stimuli;
  logic [15:0]        connection;
  logic               enable;
  logic               picture_done;
  logic [15:0]        spike_i;
  logic [15:0]        spike_out;
  logic               spike_valid;
  logic               busy;
  logic [2:0]         dbg_state_o;

  snn_axon_scheduler #(.NUM_AXONS(256), .ADDR_W(8), .NUM_NEURON(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pixel_we(pixel_we), .pixel_addr(pixel_addr), .pixel_wdata(pixel_wdata),
    .stim_weight(stim_weight), .bias(bias),
    .syn_req(syn_req), .syn_addr(syn_addr), .syn_ack(syn_ack), .syn_data(syn_data),
    .stimuli(stimuli), .connection(connection), .enable(enable),
    .picture_done(picture_done), .spike_i(spike_i), .spike_out(spike_out),
    .spike_valid(spike_valid), .busy(busy), .dbg_state_o(dbg_state_o)
  );

  // ---------------- test state ----------------
  logic [15:0]        mem [NA];
  logic [NA-1:0]      bm_cur = '0;
  logic signed [15:0] w_cur = '0;
  logic signed [15:0] bias_cur = '0;
  logic [31:0]        exp_q[$];
  logic [31:0]        addr_q[$];
  int                 n_total = 0;
  int                 n_pass = 0;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- neuron block emulation ----------------
  logic [15:0] pot [16];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 16; n++) pot[n] <= '0;
    end else if (picture_done) begin
      for (int n = 0; n < 16; n++) pot[n] <= '0;
    end else if (enable) begin
      for (int n = 0; n < 16; n++)
        if (connection[n]) pot[n] <= pot[n] + stimuli;
    end
  end
  always_comb begin
    spike_i = '0;
    for (int n = 0; n < 16; n++) spike_i[n] = ~pot[n][15];
  end

  // ---------------- synapse matrix responder ----------------
  logic resp_en = 1'b1;
  int   fix_delay = 0;
  int   cur_delay = 0;
  int   wcnt = 0;
  int   wait_sum = 0;
  always @(negedge clk) begin
    if (resp_en) begin
      if (syn_ack) begin
        syn_ack  = 1'b0;
        syn_data = 16'($urandom);
      end else if (syn_req) begin
        if (wcnt >= cur_delay) begin
          syn_ack  = 1'b1;
          syn_data = mem[syn_addr];
          wait_sum += wcnt + 1;
          wcnt = 0;
          cur_delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic set_delay(input int d);
    fix_delay = d;
    cur_delay = (d >= 0) ? d : int'($urandom_range(0, 3));
  endtask

  // ---------------- reference model ----------------
  // Each neuron sums bias plus the weight of every active axon connected to
  // it, modulo 2^16; it spikes when that sum is non-negative.
  function automatic logic [15:0] model_spikes();
    logic [15:0] res;
    logic [15:0] acc;
    res = '0;
    for (int n = 0; n < 16; n++) begin
      acc = bias_cur;
      for (int a = 0; a < NA; a++)
        if (bm_cur[a] && mem[a][n]) acc = acc + w_cur;
      res[n] = ~acc[15];
    end
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_bitmap();
    for (int wd = 0; wd < NA / 32; wd++) begin
      @(negedge clk);
      pixel_we    = 1'b1;
      pixel_addr  = 3'(wd);
      pixel_wdata = bm_cur[wd*32 +: 32];
    end
    @(negedge clk);
    pixel_we = 1'b0;
  endtask

  task automatic random_rows();
    for (int a = 0; a < NA; a++) mem[a] = 16'($urandom);
  endtask

  // Runs one picture and scores it. pre_started: start was already raised
  // in the previous spike_valid cycle. chain: raise start in this picture's
  // spike_valid cycle. poke: fire start/pixel_we while busy.
  task automatic run_picture(input bit pre_started, input bit chain, input bit poke);
    int          lat;
    int          pd_cnt;
    int          busy_low;
    logic        prev_req;
    logic [7:0]  held;
    int          en_cyc[$];
    logic [15:0] exp_spk;
    exp_q.delete();
    addr_q.delete();
    for (int a = 0; a < NA; a++)
      if (bm_cur[a]) begin
        addr_q.push_back(32'(a));
        exp_q.push_back({mem[a], w_cur});
      end
    exp_q.push_back({16'hFFFF, bias_cur});
    exp_spk     = model_spikes();
    stim_weight = w_cur;
    bias        = bias_cur;
    wait_sum    = 0;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    lat = 0; pd_cnt = 0; busy_low = 0; prev_req = 1'b0; held = '0;
    for (int k = 1; k <= 3000; k++) begin
      if (poke && k == 10) begin
        start = 1'b1; pixel_we = 1'b1; pixel_addr = '0; pixel_wdata = ~bm_cur[31:0];
      end
      if (poke && k == 11) begin
        start = 1'b0; pixel_we = 1'b0;
      end
      if (syn_req && !prev_req) begin
        held = syn_addr;
        if (addr_q.size() > 0) chk("req_addr", 32'(syn_addr), addr_q.pop_front());
        else chk("req_extra", 32'(syn_addr), 32'hFFFF_FFFF);
      end else if (syn_req) begin
        chk("req_hold", 32'(syn_addr), 32'(held));
      end
      prev_req = syn_req;
      if (enable) begin
        en_cyc.push_back(k);
        if (exp_q.size() > 0) chk("en_pulse", {connection, stimuli}, exp_q.pop_front());
        else chk("en_extra", {connection, stimuli}, 32'hDEAD_BEEF);
      end
      if (picture_done) pd_cnt++;
      if (spike_valid) begin
        lat = k;
        break;
      end
      if (!busy) busy_low++;
      @(negedge clk);
    end
    if (lat == 0) begin
      chk("timeout", 0, 1);
    end else begin
      chk("latency", 32'(lat), 32'(260 + wait_sum));
      chk("spike_out", 32'(spike_out), 32'(exp_spk));
      chk("busy_at_valid", 32'(busy), 0);
      chk("pd_count", 32'(pd_cnt), 1);
      chk("pulses_left", 32'(exp_q.size() + addr_q.size()), 0);
      chk("busy_drop", 32'(busy_low), 0);
      if (en_cyc.size() > 0) chk("bias_cyc", 32'(en_cyc[en_cyc.size()-1]), 32'(lat - 2));
      if (bm_cur[NA-1] && en_cyc.size() > 1)
        chk("last_axon_cyc", 32'(en_cyc[en_cyc.size()-2]), 32'(lat - 3));
    end
    if (chain) begin
      start = 1'b1;
    end else begin
      @(negedge clk);
      chk("sv_one_cycle", 32'(spike_valid), 0);
    end
  endtask

  task automatic random_picture(input int dens, input bit wide_w);
    for (int a = 0; a < NA; a++) bm_cur[a] = ($urandom_range(0, 99) < dens);
    random_rows();
    w_cur    = wide_w ? 16'($urandom) : 16'($signed($urandom_range(0, 200)) - 100);
    bias_cur = 16'($signed($urandom_range(0, 600)) - 300);
    write_bitmap();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(syn_req), 0);
    chk("rst_en", 32'(enable), 0);
    chk("rst_pd", 32'(picture_done), 0);
    chk("rst_sv", 32'(spike_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_spike", 32'(spike_out), 0);
    chk("rst_conn", {connection, stimuli}, 0);
    chk("rst_state", 32'(dbg_state_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single active axon
    bm_cur = '0; bm_cur[0] = 1'b1;
    random_rows(); mem[0] = 16'h00FF;
    w_cur = 16'sd5; bias_cur = -16'sd3;
    set_delay(0);
    write_bitmap();
    run_picture(0, 0, 0);
    chk("single_spike", 32'(spike_out), 32'h00FF);

    // Empty picture, both threshold signs
    bm_cur = '0; write_bitmap();
    bias_cur = -16'sd1; run_picture(0, 0, 0);
    chk("empty_neg", 32'(spike_out), 32'h0000);
    bias_cur = 16'sd0; run_picture(0, 0, 0);
    chk("empty_zero", 32'(spike_out), 32'hFFFF);

    // Edge axons with delayed ack
    bm_cur = '0; bm_cur[0] = 1'b1; bm_cur[NA-1] = 1'b1;
    random_rows(); w_cur = 16'sd7; bias_cur = -16'sd4;
    set_delay(3);
    write_bitmap();
    run_picture(0, 0, 0);

    // Ignored start / pixel_we while busy, then the same picture again
    set_delay(-1);
    random_picture(20, 0);
    run_picture(0, 0, 1);
    run_picture(0, 0, 0);

    // Stray ack while idle
    @(negedge clk);
    resp_en = 1'b0;
    syn_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_state", 32'(dbg_state_o), 0);
      chk("stray_en", 32'(enable), 0);
      chk("stray_req", 32'(syn_req), 0);
    end
    syn_ack = 1'b0;
    resp_en = 1'b1;

    // Back-to-back pictures
    random_picture(15, 0);
    run_picture(0, 1, 0);
    run_picture(1, 0, 0);

    // Randomized pictures
    for (int r = 0; r < 6; r++) begin
      random_picture(int'($urandom_range(0, 40)), r[0]);
      run_picture(0, 0, 0);
    end

    // Reset while waiting for an ack
    bm_cur = '0; bm_cur[5] = 1'b1;
    write_bitmap();
    resp_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (syn_req) break;
      @(negedge clk);
    end
    chk("pre_rst_req", 32'(syn_req), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(syn_req), 0);
    chk("midrst_en", 32'(enable), 0);
    chk("midrst_pd", 32'(picture_done), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_state", 32'(dbg_state_o), 0);
    @(negedge clk);
    rst = 1'b0;
    wcnt = 0;
    resp_en = 1'b1;
    set_delay(0);
    // Reset cleared the bitmap: the next start sees an empty picture.
    bm_cur = '0;
    bias_cur = -16'sd5;
    run_picture(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
